uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz SHALL be provided.
REQ-002 Parameter BAUD, default 115200, serial bit rate SHALL be provided.
REQ-003 Parameter FRAME_BITS, default 11, bit times reserved per byte (start, 8 data, stop, guard), SHALL be provided.
REQ-004 Ports SHALL be, clock and reset first (name, direction, width, meaning):
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 (CPU) has a byte.
- req0_data  input  8  requester 0 byte.
- req0_ready  output  1  requester 0 byte accepted this cycle.
- req1_valid  input  1  requester 1 (debug) has a byte.
- req1_data  input  8  requester 1 byte.
- req1_ready  output  1  requester 1 byte accepted this cycle.
- uart_wr_o  output  1  one-cycle write strobe to the UART transmitter.
- uart_dat_o  output  8  byte to the transmitter, valid while uart_wr_o=1.
- busy  output  1  high in any state other than IDLE.
- tx_count  output  16  bytes issued to the transmitter since reset.

Function
REQ-005 FRAME_CYCLES SHALL equal ceil(FRAME_BITS*CLK_HZ/BAUD), computed at elaboration (9549 at defaults).
REQ-006 The FSM SHALL have states IDLE, ISSUE, WAIT, with CR and CR_WAIT added when UART_TX_CRLF_EN is defined.
REQ-007 A transfer SHALL occur on a cycle where reqN_valid=1 and reqN_ready=1.
REQ-008 reqN_ready SHALL be combinational, high only in IDLE, for the granted requester only, and at most one ready SHALL be high per cycle.
REQ-009 Arbitration SHALL be round-robin. With both valid, grant the requester not granted last. With one valid, grant it.
REQ-010 last_grant SHALL update only on a transfer.
REQ-011 Requesters SHALL hold valid and data stable until ready. The block SHALL NOT sample data except on a transfer.
REQ-012 On a transfer in cycle N, the byte SHALL be latched and the FSM SHALL enter ISSUE. uart_wr_o=1 with uart_dat_o=byte in cycle N+1.
REQ-013 ISSUE SHALL last exactly one cycle, then WAIT.
REQ-014 WAIT SHALL last exactly FRAME_CYCLES cycles, then IDLE. The next transfer is possible no earlier than cycle N+2+FRAME_CYCLES.
REQ-015 uart_wr_o SHALL be 0 in every state other than ISSUE (and CR). uart_dat_o SHALL hold its last value otherwise.
REQ-016 tx_count SHALL increment by 1 on every cycle uart_wr_o=1 and wrap from 0xFFFF to 0x0000.
REQ-017 Valid deasserting during ISSUE or WAIT SHALL have no effect on the byte in flight.

Reset
REQ-018 Asserting reset (low) at any time, including mid-WAIT, SHALL immediately force:
- state=IDLE, uart_wr_o=0, uart_dat_o=0x00, tx_count=0, wait counter=0.
- last_grant=1, so requester 0 wins the first contention.
REQ-019 The first transfer SHALL be possible in the first clock edge after reset deasserts.

Configuration
REQ-020 With macro UART_TX_CRLF_EN defined, an accepted byte 0x0A SHALL follow IDLE->CR->CR_WAIT->ISSUE->WAIT->IDLE:
- CR: one cycle, uart_wr_o=1 with 0x0D.
- CR_WAIT: FRAME_CYCLES cycles.
- ISSUE: sends 0x0A.
- tx_count increases by 2.
REQ-021 Without UART_TX_CRLF_EN, CR and CR_WAIT SHALL not exist and 0x0A SHALL be sent unmodified like any byte.

Verification
All scenarios use CLK_HZ=1000, BAUD=100, FRAME_BITS=11, giving FRAME_CYCLES=110.
REQ-022 Single byte:
- Stimulus: req0 sends 0x55 at cycle N.
- Response: req0_ready=1 at N; uart_wr_o=1 with 0x55 only at N+1; busy through N+111; IDLE at N+112; tx_count=1.
REQ-023 Contention:
- Stimulus: req0 and req1 both valid continuously with 0xA1 and 0xB2 after reset.
- Response: issue order 0xA1, 0xB2, 0xA1, 0xB2; strobes 112 cycles apart.
REQ-024 Reset mid-op:
- Stimulus: reset low at cycle 50 of WAIT.
- Response: uart_wr_o=0, busy=0, tx_count=0 immediately; a new req1 byte is accepted on the first edge after release.
REQ-025 Wrap:
- Stimulus: preload 65535 transfers (or force tx_count=0xFFFF), then send one byte.
- Response: tx_count=0x0000.
REQ-026 CRLF:
- Stimulus: req0 sends 0x0A.
- Response with UART_TX_CRLF_EN: strobes 0x0D then 0x0A, 111 cycles apart, tx_count += 2.
- Response without the macro: a single strobe with 0x0A, tx_count += 1.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: two-requester round-robin front end for a UART transmitter.
// Each accepted byte is issued as a one-cycle strobe. The block then stays busy
// for one full frame time, so the transmitter is never overrun.
// Optional feature macro UART_TX_CRLF_EN: an accepted 0x0A is preceded by 0x0D,
// and the 0x0D gets its own frame time.
module uart_tx_ctrl #(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FRAME_BITS = 11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       uart_wr_o,
   output logic [7:0] uart_dat_o,
   output logic       busy,
   output logic [15:0] tx_count
);

   // Frame time in clock cycles, rounded up so a frame is never cut short.
   localparam logic [63:0] FRAME_NUM    = 64'(FRAME_BITS) * 64'(CLK_HZ);
   localparam logic [63:0] FRAME_CYC64  = (FRAME_NUM + 64'(BAUD) - 64'd1) / 64'(BAUD);
   localparam int unsigned FRAME_CYCLES = FRAME_CYC64[31:0];
   localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT
`ifdef UART_TX_CRLF_EN
      ,
      CR,
      CR_WAIT
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q;
   logic             last_grant_q;
   logic [7:0]       dat_q;
   logic [15:0]      tx_cnt_q;
   logic             gnt0, gnt1, xfer;
   logic [7:0]       sel_data;
   logic             in_wait, wait_done;
`ifdef UART_TX_CRLF_EN
   logic [7:0]       byte_q;
`endif

   assign xfer       = gnt0 | gnt1;
   assign sel_data   = gnt1 ? req1_data : req0_data;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign busy       = (state_q != IDLE);
   assign uart_dat_o = dat_q;
   assign tx_count   = tx_cnt_q;
   assign wait_done  = (wait_cnt_q == CNT_LAST);

   // Round-robin grant, offered only in IDLE; requester 0 wins when last_grant points at 1.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == IDLE) begin
         if (req0_valid && (!req1_valid || last_grant_q))
            gnt0 = 1'b1;
         else if (req1_valid)
            gnt1 = 1'b1;
      end
   end

   // Next-state logic and decoded strobe / wait qualifiers.
   always_comb begin
      state_d   = state_q;
      uart_wr_o = 1'b0;
      in_wait   = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) begin
`ifdef UART_TX_CRLF_EN
               state_d = (sel_data == 8'h0A) ? CR : ISSUE;
`else
               state_d = ISSUE;
`endif
            end
         end
         ISSUE: begin
            uart_wr_o = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            in_wait = 1'b1;
            if (wait_done)
               state_d = IDLE;
         end
`ifdef UART_TX_CRLF_EN
         CR: begin
            uart_wr_o = 1'b1;
            state_d   = CR_WAIT;
         end
         CR_WAIT: begin
            in_wait = 1'b1;
            if (wait_done)
               state_d = ISSUE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Frame-time counter: runs only in the wait states and clears when the frame ends.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wait_cnt_q <= '0;
      else if (in_wait && !wait_done)
         wait_cnt_q <= wait_cnt_q + 1'b1;
      else
         wait_cnt_q <= '0;
   end

   // Arbitration history changes only when a byte is actually taken.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last_grant_q <= 1'b1;
      else if (xfer)
         last_grant_q <= gnt1;
   end

   // Output byte register: loaded on acceptance, and held between strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dat_q <= 8'h00;
`ifdef UART_TX_CRLF_EN
         byte_q <= 8'h00;
`endif
      end else if (xfer) begin
`ifdef UART_TX_CRLF_EN
         byte_q <= sel_data;
         dat_q  <= (sel_data == 8'h0A) ? 8'h0D : sel_data;
`else
         dat_q  <= sel_data;
`endif
      end
`ifdef UART_TX_CRLF_EN
      else if (state_q == CR_WAIT && wait_done) begin
         dat_q <= byte_q;
      end
`endif
   end

   // Count of strobes issued to the transmitter; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         tx_cnt_q <= 16'h0000;
      else if (uart_wr_o)
         tx_cnt_q <= tx_cnt_q + 16'd1;
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a frame time of 110 cycles
// (CLK_HZ=1000, BAUD=100, FRAME_BITS=11).
module tb_uart_tx_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0_valid = 1'b0;
   logic [7:0]  req0_data = 8'h00;
   logic        req1_valid = 1'b0;
   logic [7:0]  req1_data = 8'h00;
   logic        req0_ready, req1_ready;
   logic        uart_wr_o;
   logic [7:0]  uart_dat_o;
   logic        busy;
   logic [15:0] tx_count;

   int checks = 0;
   int errors = 0;

   uart_tx_ctrl #(.CLK_HZ(1000), .BAUD(100), .FRAME_BITS(11)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .uart_wr_o  (uart_wr_o),
      .uart_dat_o (uart_dat_o),
      .busy       (busy),
      .tx_count   (tx_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int nstr;
      int k;
      int st_t[4];
      logic [7:0] st_d[4];
      int exp_tc;

      // reset state
      cyc(2);
      chk("rst_wr", 32'(uart_wr_o), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(tx_count), 32'd0);
      chk("rst_dat", 32'(uart_dat_o), 32'd0);

      // single byte from req0, accepted on the first edge after release
      reset = 1'b1;
      req0_valid = 1'b1;
      req0_data  = 8'h55;
      #1;
      chk("single_rdy0", 32'(req0_ready), 32'd1);
      chk("single_rdy1", 32'(req1_ready), 32'd0);
      cyc(1);
      chk("single_wr", 32'(uart_wr_o), 32'd1);
      chk("single_dat", 32'(uart_dat_o), 32'h55);
      chk("single_busy", 32'(busy), 32'd1);
      req0_valid = 1'b0;
      nstr = 0;
      for (int t = 2; t <= 111; t++) begin
         cyc(1);
         if (uart_wr_o) nstr++;
         if (t == 50) begin
            req0_valid = 1'b1;
            req0_data  = 8'h77;
            #1;
            chk("wait_no_rdy", 32'(req0_ready), 32'd0);
         end
         if (t == 51) req0_valid = 1'b0;
      end
      chk("single_extra_strobes", 32'(nstr), 32'd0);
      chk("single_busy_end", 32'(busy), 32'd1);
      chk("single_dat_hold", 32'(uart_dat_o), 32'h55);
      cyc(1);
      chk("single_idle", 32'(busy), 32'd0);
      chk("single_cnt", 32'(tx_count), 32'd1);

      // contention after a fresh reset: req0 first, then alternate
      reset = 1'b0;
      #1;
      chk("rst2_cnt", 32'(tx_count), 32'd0);
      cyc(1);
      reset = 1'b1;
      req0_valid = 1'b1;
      req0_data  = 8'hA1;
      req1_valid = 1'b1;
      req1_data  = 8'hB2;
      #1;
      chk("cont_rdy0", 32'(req0_ready), 32'd1);
      chk("cont_rdy1", 32'(req1_ready), 32'd0);
      k = 0;
      for (int t = 1; t <= 340; t++) begin
         cyc(1);
         if (t == 112) begin
            chk("cont_rr_rdy1", 32'(req1_ready), 32'd1);
            chk("cont_rr_rdy0", 32'(req0_ready), 32'd0);
         end
         if (uart_wr_o) begin
            if (k < 4) begin
               st_t[k] = t;
               st_d[k] = uart_dat_o;
            end
            k++;
         end
      end
      chk("cont_nstrobes", 32'(k), 32'd4);
      chk("cont_t0", 32'(st_t[0]), 32'd1);
      chk("cont_t1", 32'(st_t[1]), 32'd113);
      chk("cont_t2", 32'(st_t[2]), 32'd225);
      chk("cont_t3", 32'(st_t[3]), 32'd337);
      chk("cont_d0", 32'(st_d[0]), 32'hA1);
      chk("cont_d1", 32'(st_d[1]), 32'hB2);
      chk("cont_d2", 32'(st_d[2]), 32'hA1);
      chk("cont_d3", 32'(st_d[3]), 32'hB2);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("cont_cnt", 32'(tx_count), 32'd4);

      // reset asserted at WAIT cycle 50 of the fourth byte
      cyc(47);
      chk("mid_busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_wr", 32'(uart_wr_o), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_cnt", 32'(tx_count), 32'd0);
      chk("mid_dat", 32'(uart_dat_o), 32'd0);
      cyc(1);
      reset = 1'b1;
      req1_valid = 1'b1;
      req1_data  = 8'h3C;
      #1;
      chk("post_rdy1", 32'(req1_ready), 32'd1);
      chk("post_rdy0", 32'(req0_ready), 32'd0);
      cyc(1);
      chk("post_wr", 32'(uart_wr_o), 32'd1);
      chk("post_dat", 32'(uart_dat_o), 32'h3C);
      req1_valid = 1'b0;
      cyc(111);
      chk("post_idle", 32'(busy), 32'd0);
      chk("post_cnt", 32'(tx_count), 32'd1);

      // line feed byte
      req0_valid = 1'b1;
      req0_data  = 8'h0A;
      #1;
      chk("lf_rdy0", 32'(req0_ready), 32'd1);
      k = 0;
      for (int t = 1; t <= 223; t++) begin
         cyc(1);
         if (t == 1) req0_valid = 1'b0;
         if (uart_wr_o) begin
            if (k < 4) begin
               st_t[k] = t;
               st_d[k] = uart_dat_o;
            end
            k++;
         end
      end
`ifdef UART_TX_CRLF_EN
      chk("lf_nstrobes", 32'(k), 32'd2);
      chk("lf_t0", 32'(st_t[0]), 32'd1);
      chk("lf_d0", 32'(st_d[0]), 32'h0D);
      chk("lf_t1", 32'(st_t[1]), 32'd112);
      chk("lf_d1", 32'(st_d[1]), 32'h0A);
      exp_tc = 3;
`else
      chk("lf_nstrobes", 32'(k), 32'd1);
      chk("lf_t0", 32'(st_t[0]), 32'd1);
      chk("lf_d0", 32'(st_d[0]), 32'h0A);
      exp_tc = 2;
`endif
      chk("lf_idle", 32'(busy), 32'd0);
      chk("lf_cnt", 32'(tx_count), 32'(exp_tc));

      // counter wrap from 0xFFFF
      #1;
      force dut.tx_cnt_q = 16'hFFFF;
      #1;
      release dut.tx_cnt_q;
      #1;
      chk("wrap_preload", 32'(tx_count), 32'hFFFF);
      req1_valid = 1'b1;
      req1_data  = 8'h99;
      #1;
      chk("wrap_rdy1", 32'(req1_ready), 32'd1);
      cyc(1);
      req1_valid = 1'b0;
      chk("wrap_wr", 32'(uart_wr_o), 32'd1);
      chk("wrap_dat", 32'(uart_dat_o), 32'h99);
      cyc(1);
      chk("wrap_cnt", 32'(tx_count), 32'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
